serial_port_buffer: RTL and testbench

- Parametrised buffered serial bridge between the processor's serial handshake pins and an external byte-stream endpoint (console model or UART).
- Provides independent TX and RX FIFOs, occupancy counts, sticky drop/overflow flags and a runtime loopback mode.
- Lets the processor burst-write or burst-read without the external side being ready every cycle.

---
 rtl/serial_port_buffer.sv | 126 ++++++++++++
 tb/tb_serial_port_buffer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_port_buffer.sv
// Buffered serial bridge: processor-side handshake to an external byte stream, with separate
// TX/RX FIFOs, occupancy counts, sticky error flags and a runtime loopback path.
module serial_port_buffer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned TX_DEPTH   = 16,
  parameter int unsigned RX_DEPTH   = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [DATA_WIDTH-1:0]       cpu_wdata,
  input  logic                        cpu_wren,
  output logic                        cpu_tx_ready,
  input  logic                        cpu_rden,
  output logic [DATA_WIDTH-1:0]       cpu_rdata,
  output logic                        cpu_rx_valid,
  output logic [DATA_WIDTH-1:0]       line_tx_data,
  output logic                        line_tx_valid,
  input  logic                        line_tx_ready,
  input  logic [DATA_WIDTH-1:0]       line_rx_data,
  input  logic                        line_rx_valid,
  output logic                        line_rx_ready,
  input  logic                        loopback,
  input  logic                        clear_flags,
  output logic [$clog2(TX_DEPTH):0]   tx_count,
  output logic [$clog2(RX_DEPTH):0]   rx_count,
  output logic                        tx_drop,
  output logic                        rx_underflow
);

  localparam int unsigned TxAw = $clog2(TX_DEPTH);
  localparam int unsigned RxAw = $clog2(RX_DEPTH);
  localparam logic [TxAw:0] TxOne = 1;
  localparam logic [RxAw:0] RxOne = 1;

  logic [DATA_WIDTH-1:0] tx_mem_q [TX_DEPTH];
  logic [DATA_WIDTH-1:0] rx_mem_q [RX_DEPTH];
  logic [TxAw:0]         tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [RxAw:0]         rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [DATA_WIDTH-1:0] tx_last_q, rx_last_q;
  logic                  loopback_q;
  logic                  tx_drop_q, tx_drop_d, rx_underflow_q, rx_underflow_d;

  logic                  tx_full, tx_empty, rx_full, rx_empty;
  logic                  tx_push, tx_pop, rx_push, rx_pop;
  logic [DATA_WIDTH-1:0] tx_head, rx_head, rx_wdata;

  // Extra wrap bit: equal low bits with differing MSB means full.
  assign tx_empty = (tx_wr_q == tx_rd_q);
  assign tx_full  = (tx_wr_q[TxAw] != tx_rd_q[TxAw]) &&
                    (tx_wr_q[TxAw-1:0] == tx_rd_q[TxAw-1:0]);
  assign rx_empty = (rx_wr_q == rx_rd_q);
  assign rx_full  = (rx_wr_q[RxAw] != rx_rd_q[RxAw]) &&
                    (rx_wr_q[RxAw-1:0] == rx_rd_q[RxAw-1:0]);

  assign tx_head = tx_mem_q[tx_rd_q[TxAw-1:0]];
  assign rx_head = rx_mem_q[rx_rd_q[RxAw-1:0]];

  assign cpu_tx_ready  = !tx_full;
  assign cpu_rx_valid  = !rx_empty;
  assign line_tx_valid = !tx_empty && !loopback_q;
  assign line_rx_ready = !rx_full && !loopback_q;
  // Heads hold their last shown value once the FIFO drains.
  assign line_tx_data  = tx_empty ? tx_last_q : tx_head;
  assign cpu_rdata     = rx_empty ? rx_last_q : rx_head;

  assign tx_count     = tx_wr_q - tx_rd_q;
  assign rx_count     = rx_wr_q - rx_rd_q;
  assign tx_drop      = tx_drop_q;
  assign rx_underflow = rx_underflow_q;

  always_comb begin
    tx_push  = cpu_wren && !tx_full;
    rx_pop   = cpu_rden && !rx_empty;
    tx_pop   = 1'b0;
    rx_push  = 1'b0;
    rx_wdata = line_rx_data;
    if (loopback_q) begin
      tx_pop   = !tx_empty && !rx_full;
      rx_push  = tx_pop;
      rx_wdata = tx_head;
    end else begin
      tx_pop   = line_tx_valid && line_tx_ready;
      rx_push  = line_rx_valid && line_rx_ready;
    end

    tx_wr_d = tx_push ? tx_wr_q + TxOne : tx_wr_q;
    tx_rd_d = tx_pop  ? tx_rd_q + TxOne : tx_rd_q;
    rx_wr_d = rx_push ? rx_wr_q + RxOne : rx_wr_q;
    rx_rd_d = rx_pop  ? rx_rd_q + RxOne : rx_rd_q;

    // A set condition beats a simultaneous clear.
    tx_drop_d      = (cpu_wren && tx_full) || (tx_drop_q && !clear_flags);
    rx_underflow_d = (cpu_rden && rx_empty) || (rx_underflow_q && !clear_flags);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_wr_q        <= '0;
      tx_rd_q        <= '0;
      rx_wr_q        <= '0;
      rx_rd_q        <= '0;
      tx_last_q      <= '0;
      rx_last_q      <= '0;
      loopback_q     <= loopback;
      tx_drop_q      <= 1'b0;
      rx_underflow_q <= 1'b0;
    end else begin
      tx_wr_q        <= tx_wr_d;
      tx_rd_q        <= tx_rd_d;
      rx_wr_q        <= rx_wr_d;
      rx_rd_q        <= rx_rd_d;
      tx_last_q      <= line_tx_data;
      rx_last_q      <= cpu_rdata;
      loopback_q     <= loopback;
      tx_drop_q      <= tx_drop_d;
      rx_underflow_q <= rx_underflow_d;
    end
  end

  // Storage needs no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clock) begin
    if (!reset && tx_push) tx_mem_q[tx_wr_q[TxAw-1:0]] <= cpu_wdata;
    if (!reset && rx_push) rx_mem_q[rx_wr_q[RxAw-1:0]] <= rx_wdata;
  end

endmodule

// File: tb/tb_serial_port_buffer.sv
// Directed self-checking bench for serial_port_buffer: fill/drain, RX path, loopback,
// steady-state wrap and mid-operation reset.
module tb_serial_port_buffer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] cpu_wdata = '0;
  logic       cpu_wren = 1'b0;
  logic       cpu_tx_ready;
  logic       cpu_rden = 1'b0;
  logic [7:0] cpu_rdata;
  logic       cpu_rx_valid;
  logic [7:0] line_tx_data;
  logic       line_tx_valid;
  logic       line_tx_ready = 1'b0;
  logic [7:0] line_rx_data = '0;
  logic       line_rx_valid = 1'b0;
  logic       line_rx_ready;
  logic       loopback = 1'b0;
  logic       clear_flags = 1'b0;
  logic [4:0] tx_count;
  logic [4:0] rx_count;
  logic       tx_drop;
  logic       rx_underflow;

  int total = 0;
  int bad = 0;

  serial_port_buffer #(.DATA_WIDTH(8), .TX_DEPTH(16), .RX_DEPTH(16)) dut (
    .clock(clock), .reset(reset),
    .cpu_wdata(cpu_wdata), .cpu_wren(cpu_wren), .cpu_tx_ready(cpu_tx_ready),
    .cpu_rden(cpu_rden), .cpu_rdata(cpu_rdata), .cpu_rx_valid(cpu_rx_valid),
    .line_tx_data(line_tx_data), .line_tx_valid(line_tx_valid), .line_tx_ready(line_tx_ready),
    .line_rx_data(line_rx_data), .line_rx_valid(line_rx_valid), .line_rx_ready(line_rx_ready),
    .loopback(loopback), .clear_flags(clear_flags),
    .tx_count(tx_count), .rx_count(rx_count), .tx_drop(tx_drop), .rx_underflow(rx_underflow)
  );

  always #5 clock = ~clock;

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (10) tick();
    reset = 1'b0;
    total++; if (tx_count !== 5'd0) begin bad++; $display("FAIL reset_tx_count got %0d want 0", tx_count); end
    total++; if (rx_count !== 5'd0) begin bad++; $display("FAIL reset_rx_count got %0d want 0", rx_count); end
    total++; if (cpu_tx_ready !== 1'b1) begin bad++; $display("FAIL reset_tx_ready got %b want 1", cpu_tx_ready); end
    total++; if (cpu_rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid got %b want 0", cpu_rx_valid); end
    total++; if (line_tx_valid !== 1'b0) begin bad++; $display("FAIL reset_line_tx_valid got %b want 0", line_tx_valid); end
    total++; if (line_rx_ready !== 1'b1) begin bad++; $display("FAIL reset_line_rx_ready got %b want 1", line_rx_ready); end
    total++; if ({tx_drop, rx_underflow} !== 2'b00) begin bad++; $display("FAIL reset_flags got %b want 00", {tx_drop, rx_underflow}); end
    total++; if (cpu_rdata !== 8'h00 || line_tx_data !== 8'h00) begin bad++; $display("FAIL reset_data got %h/%h want 00/00", cpu_rdata, line_tx_data); end
  endtask

  task automatic test_tx_fill_drain();
    logic [7:0] exp [16];
    for (int i = 0; i < 16; i++) exp[i] = 8'h10 + 8'(i);
    exp[0] = 8'h48;
    exp[1] = 8'h69;
    for (int i = 0; i < 16; i++) begin
      cpu_wdata = exp[i];
      cpu_wren  = 1'b1;
      tick();
      if (i == 0) begin
        total++; if (line_tx_valid !== 1'b1 || line_tx_data !== 8'h48) begin bad++; $display("FAIL tx_latency got %b/%h want 1/48", line_tx_valid, line_tx_data); end
      end
    end
    cpu_wren = 1'b0;
    total++; if (tx_count !== 5'd16) begin bad++; $display("FAIL tx_full_count got %0d want 16", tx_count); end
    total++; if (cpu_tx_ready !== 1'b0) begin bad++; $display("FAIL tx_full_ready got %b want 0", cpu_tx_ready); end
    total++; if (tx_drop !== 1'b0) begin bad++; $display("FAIL tx_drop_early got %b want 0", tx_drop); end
    cpu_wdata = 8'hFF;
    cpu_wren  = 1'b1;
    tick();
    cpu_wren  = 1'b0;
    total++; if (tx_drop !== 1'b1) begin bad++; $display("FAIL tx_drop_set got %b want 1", tx_drop); end
    total++; if (tx_count !== 5'd16) begin bad++; $display("FAIL tx_drop_count got %0d want 16", tx_count); end
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    total++; if (tx_drop !== 1'b0) begin bad++; $display("FAIL tx_drop_clear got %b want 0", tx_drop); end
    // Push while full alongside the first pop: full is judged before the edge, so it drops.
    line_tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cpu_wren  = (i == 0);
      cpu_wdata = 8'hEE;
      total++; if (line_tx_valid !== 1'b1 || line_tx_data !== exp[i]) begin bad++; $display("FAIL tx_drain[%0d] got %b/%h want 1/%h", i, line_tx_valid, line_tx_data, exp[i]); end
      tick();
      if (i == 0) begin
        total++; if (tx_drop !== 1'b1 || tx_count !== 5'd15) begin bad++; $display("FAIL tx_full_push_pop got %b/%0d want 1/15", tx_drop, tx_count); end
      end
    end
    cpu_wren = 1'b0;
    line_tx_ready = 1'b0;
    total++; if (tx_count !== 5'd0 || line_tx_valid !== 1'b0) begin bad++; $display("FAIL tx_drained got %0d/%b want 0/0", tx_count, line_tx_valid); end
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
  endtask

  task automatic test_rx_read();
    logic [7:0] exp [3];
    exp[0] = 8'h41; exp[1] = 8'h42; exp[2] = 8'h43;
    for (int i = 0; i < 3; i++) begin
      line_rx_data  = exp[i];
      line_rx_valid = 1'b1;
      tick();
    end
    line_rx_valid = 1'b0;
    total++; if (rx_count !== 5'd3) begin bad++; $display("FAIL rx_count3 got %0d want 3", rx_count); end
    total++; if (cpu_rx_valid !== 1'b1 || cpu_rdata !== 8'h41) begin bad++; $display("FAIL rx_head got %b/%h want 1/41", cpu_rx_valid, cpu_rdata); end
    for (int i = 0; i < 3; i++) begin
      total++; if (cpu_rdata !== exp[i]) begin bad++; $display("FAIL rx_read[%0d] got %h want %h", i, cpu_rdata, exp[i]); end
      cpu_rden = 1'b1;
      tick();
      cpu_rden = 1'b0;
      tick();
    end
    total++; if (rx_count !== 5'd0 || cpu_rx_valid !== 1'b0 || cpu_rdata !== 8'h43) begin bad++; $display("FAIL rx_empty_hold got %0d/%b/%h want 0/0/43", rx_count, cpu_rx_valid, cpu_rdata); end
    total++; if (rx_underflow !== 1'b0) begin bad++; $display("FAIL rx_underflow_early got %b want 0", rx_underflow); end
    cpu_rden = 1'b1;
    tick();
    cpu_rden = 1'b0;
    total++; if (rx_underflow !== 1'b1 || rx_count !== 5'd0) begin bad++; $display("FAIL rx_underflow_set got %b/%0d want 1/0", rx_underflow, rx_count); end
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    total++; if (rx_underflow !== 1'b0) begin bad++; $display("FAIL rx_underflow_clear got %b want 0", rx_underflow); end
    cpu_rden    = 1'b1;
    clear_flags = 1'b1;
    tick();
    cpu_rden    = 1'b0;
    total++; if (rx_underflow !== 1'b1) begin bad++; $display("FAIL flag_set_beats_clear got %b want 1", rx_underflow); end
    tick();
    clear_flags = 1'b0;
    total++; if (rx_underflow !== 1'b0) begin bad++; $display("FAIL flag_clear_after got %b want 0", rx_underflow); end
  endtask

  task automatic test_loopback();
    loopback = 1'b1;
    tick();
    total++; if (line_rx_ready !== 1'b0) begin bad++; $display("FAIL lb_rx_ready got %b want 0", line_rx_ready); end
    // External RX traffic must be ignored while looped back.
    line_rx_data  = 8'h99;
    line_rx_valid = 1'b1;
    cpu_wdata = 8'h55; cpu_wren = 1'b1;
    tick();
    total++; if (line_tx_valid !== 1'b0 || tx_count !== 5'd1) begin bad++; $display("FAIL lb_step1 got %b/%0d want 0/1", line_tx_valid, tx_count); end
    cpu_wdata = 8'hAA;
    tick();
    cpu_wren = 1'b0;
    total++; if (tx_count !== 5'd1 || rx_count !== 5'd1 || cpu_rdata !== 8'h55) begin bad++; $display("FAIL lb_step2 got %0d/%0d/%h want 1/1/55", tx_count, rx_count, cpu_rdata); end
    tick();
    total++; if (tx_count !== 5'd0 || rx_count !== 5'd2 || line_tx_valid !== 1'b0) begin bad++; $display("FAIL lb_step3 got %0d/%0d/%b want 0/2/0", tx_count, rx_count, line_tx_valid); end
    total++; if (cpu_rdata !== 8'h55) begin bad++; $display("FAIL lb_read0 got %h want 55", cpu_rdata); end
    cpu_rden = 1'b1;
    tick();
    total++; if (cpu_rdata !== 8'hAA) begin bad++; $display("FAIL lb_read1 got %h want aa", cpu_rdata); end
    tick();
    cpu_rden = 1'b0;
    total++; if (rx_count !== 5'd0) begin bad++; $display("FAIL lb_rx_drained got %0d want 0", rx_count); end
    line_rx_valid = 1'b0;
    loopback = 1'b0;
    tick();
    total++; if (line_rx_ready !== 1'b1) begin bad++; $display("FAIL lb_exit_ready got %b want 1", line_rx_ready); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 15; i++) begin
      line_rx_data  = 8'(i);
      line_rx_valid = 1'b1;
      tick();
    end
    total++; if (rx_count !== 5'd15) begin bad++; $display("FAIL b2b_fill got %0d want 15", rx_count); end
    cpu_rden = 1'b1;
    for (int k = 0; k < 20; k++) begin
      line_rx_data = 8'(15 + k);
      total++; if (rx_count !== 5'd15 || cpu_rdata !== 8'(k)) begin bad++; $display("FAIL b2b[%0d] got %0d/%h want 15/%h", k, rx_count, cpu_rdata, 8'(k)); end
      tick();
    end
    line_rx_valid = 1'b0;
    for (int j = 0; j < 15; j++) begin
      total++; if (cpu_rdata !== 8'(20 + j)) begin bad++; $display("FAIL b2b_drain[%0d] got %h want %h", j, cpu_rdata, 8'(20 + j)); end
      tick();
    end
    cpu_rden = 1'b0;
    total++; if (rx_count !== 5'd0) begin bad++; $display("FAIL b2b_empty got %0d want 0", rx_count); end
  endtask

  task automatic test_reset_midop();
    for (int i = 0; i < 7; i++) begin
      cpu_wdata     = 8'h70 + 8'(i);
      cpu_wren      = 1'b1;
      line_rx_data  = 8'h30 + 8'(i);
      line_rx_valid = (i < 4);
      tick();
    end
    total++; if (tx_count !== 5'd7 || rx_count !== 5'd4) begin bad++; $display("FAIL midop_counts got %0d/%0d want 7/4", tx_count, rx_count); end
    line_rx_valid = 1'b1;
    reset = 1'b1;
    tick();
    total++; if (tx_count !== 5'd0 || rx_count !== 5'd0) begin bad++; $display("FAIL midop_reset_counts got %0d/%0d want 0/0", tx_count, rx_count); end
    total++; if (line_tx_valid !== 1'b0 || cpu_rx_valid !== 1'b0) begin bad++; $display("FAIL midop_reset_valid got %b/%b want 0/0", line_tx_valid, cpu_rx_valid); end
    reset = 1'b0;
    cpu_wren = 1'b0;
    line_rx_valid = 1'b0;
    tick();
    total++; if (tx_count !== 5'd0 || rx_count !== 5'd0) begin bad++; $display("FAIL midop_after got %0d/%0d want 0/0", tx_count, rx_count); end
  endtask

  initial begin
    test_reset();
    test_tx_fill_drain();
    test_rx_read();
    test_loopback();
    test_back_to_back();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
